id_ctrl_stage: RTL and testbench
================================

# id_ctrl_stage

Instruction decode and control stage that produces the 4-bit `EXE_CMD` and the companion control bundle consumed by the ALU and the rest of the EXE stage. It accepts one 32-bit instruction per cycle and decodes the opcode into ALU command, write-back, memory and branch controls. Results are held in a registered ID/EXE boundary with valid/ready handshaking, flush, and load-use hazard stalling. It sits between instruction fetch and the EXE stage that contains the ALU.

## Interface
Parameters:
- `CNT_W`, 8, width of the saturating illegal-opcode counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  fetch presents an instruction.
- `instr`  in  32  fields: opcode [31:26], dest [25:21], src1 [20:16], src2 [15:11], imm [15:0].
- `in_ready`  out  1  instruction accepted this cycle when `in_valid & in_ready`.
- `exe_ready`  in  1  EXE stage takes the registered bundle this cycle.
- `flush`  in  1  branch taken; kill the registered bundle and the incoming instruction.
- `out_valid`  out  1  registered bundle is valid.
- `exe_cmd`  out  4  ALU command.
- `wb_en`, `mem_r_en`, `mem_w_en`, `is_imm`  out  1 each  control enables.
- `br_type`  out  2  branch kind: 0 none, 1 BEZ, 2 BNE, 3 JMP.
- `dest`, `src1`, `src2`  out  5 each  register indices.
- `imm`  out  32  `instr[15:0]` sign-extended.
- `illegal`  out  1  the registered bundle came from an undefined opcode.
- `illegal_cnt`  out  `CNT_W`  saturating count of accepted illegal opcodes.

## Operation
- `exe_cmd` encoding: ADD 0, SUB 2, AND 4, OR 5, NOR 6, XOR 7, SHL 8, SHR logical 9, SHR arithmetic 10. No other value is ever driven.
- Opcode map (opcode -> exe_cmd and controls):
  - 0 NOP -> 0, all enables 0.
  - 1 ADD -> 0; 3 SUB -> 2; 5 AND -> 4; 6 OR -> 5; 7 NOR -> 6; 8 XOR -> 7; 9 SLA -> 8; 10 SLL -> 8; 11 SRL -> 9; 12 SRA -> 10. All of these set `wb_en`.
  - 32 ADDI -> 0 and 33 SUBI -> 2, each with `wb_en` and `is_imm`.
  - 36 LD -> 0 with `wb_en`, `mem_r_en` and `is_imm`.
  - 37 ST -> 0 with `mem_w_en` and `is_imm`; `src2` = `instr[25:21]`; `wb_en` = 0.
  - 40 BEZ: `br_type` 1. 41 BNE: `br_type` 2. 42 JMP: `br_type` 3; src1/src2 are unused. All branches use `is_imm` and `exe_cmd` 0.
  - Any other opcode is decoded as NOP with `illegal` = 1.
- src2 is "used" only by R-type ALU ops (opcodes 1–12), ST and BNE.
- Advance condition: `adv = exe_ready | ~out_valid`.
- Load-use hazard: `haz` = `out_valid` & `mem_r_en` & `dest != 0` & (`src1 == dest`, or src2 is used and `src2 == dest`). The comparison uses the incoming instruction's fields against the registered bundle.
- `in_ready = flush | (adv & ~haz)`.
- Register update priority:
  1. `flush`: the bundle becomes a bubble (`out_valid` = 0, all controls 0), even if `exe_ready` = 0. The incoming instruction is consumed and discarded.
  2. `adv & haz`: load a bubble; the input is not consumed.
  3. `adv & in_valid`: load the decoded bundle with `out_valid` = 1.
  4. `adv & ~in_valid`: load a bubble.
  5. Otherwise hold every output unchanged.
- `illegal_cnt` increments on each accepted, non-flushed illegal opcode and saturates at all-ones.

## Timing
- Reset: every registered output is 0, including `out_valid`, `illegal` and `illegal_cnt`. `in_ready` = 1 immediately after reset.
- Latency: 1 cycle from acceptance to `out_valid`. Throughput is 1 instruction per cycle with no hazard and `exe_ready` held high.
- Load-use costs exactly one bubble cycle. The dependent instruction is accepted on the following edge.
- Output stability: while `out_valid & ~exe_ready & ~flush`, all outputs are stable.
- Fetch rule: the fetch side must hold `instr` stable while `in_valid & ~in_ready`.
- Reset asserted mid-stream clears the bundle asynchronously; no in-flight instruction survives.
- Decode logic and `haz` are combinational from `instr` and registered state. `in_ready` has no path from `in_valid`.

## Structure
- Shared package `ctrl_pkg` holds:
  - the `EXE_CMD` constants (ADD … SRA);
  - the opcode constants;
  - the `br_type` encoding;
  - a packed `ctrl_bundle_t` (exe_cmd, wb_en, mem_r_en, mem_w_en, is_imm, br_type, illegal).
- The ALU and EXE stage import the same package.
- Sub-module `instr_decode`: purely combinational, opcode -> `ctrl_bundle_t` plus a src2-used flag.
- The top level holds the pipeline register, hazard logic, flush and counter.

## Test plan
- Reset then stream ADD, SUB, NOR, SRA, XOR with `exe_ready` = 1 -> `exe_cmd` 0, 2, 6, 10, 7 on consecutive cycles, `wb_en` = 1, 1-cycle latency.
- LD r3 followed by ADD r4,r3,r1 -> `in_ready` = 0 for one cycle, one `out_valid` = 0 cycle, then ADD emitted. Repeat with LD r0: no stall.
- `exe_ready` = 0 for 3 cycles while holding SUBI with imm 0xFFF0 -> outputs frozen, `imm` = 0xFFFFFFF0, `in_ready` = 0.
- `flush` while `exe_ready` = 0 and ADD is registered -> next cycle `out_valid` = 0; the instruction presented with flush never appears.
- Opcode 63 accepted 300 times -> `illegal` = 1 per bundle, `exe_cmd` 0, `illegal_cnt` saturates at 255.
- Assert `rst_n` low mid-stream, asynchronously between edges -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode definitions: ALU command, branch kind, opcode map and the
// control bundle handed from ID to EXE.
package ctrl_pkg;

   typedef enum logic [3:0] {
      EXE_ADD = 4'd0,
      EXE_SUB = 4'd2,
      EXE_AND = 4'd4,
      EXE_OR  = 4'd5,
      EXE_NOR = 4'd6,
      EXE_XOR = 4'd7,
      EXE_SHL = 4'd8,
      EXE_SHR = 4'd9,
      EXE_SRA = 4'd10
   } exe_cmd_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_BEZ  = 2'd1,
      BR_BNE  = 2'd2,
      BR_JMP  = 2'd3
   } br_type_e;

   localparam logic [5:0] OP_NOP  = 6'd0;
   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_AND  = 6'd5;
   localparam logic [5:0] OP_OR   = 6'd6;
   localparam logic [5:0] OP_NOR  = 6'd7;
   localparam logic [5:0] OP_XOR  = 6'd8;
   localparam logic [5:0] OP_SLA  = 6'd9;
   localparam logic [5:0] OP_SLL  = 6'd10;
   localparam logic [5:0] OP_SRL  = 6'd11;
   localparam logic [5:0] OP_SRA  = 6'd12;
   localparam logic [5:0] OP_ADDI = 6'd32;
   localparam logic [5:0] OP_SUBI = 6'd33;
   localparam logic [5:0] OP_LD   = 6'd36;
   localparam logic [5:0] OP_ST   = 6'd37;
   localparam logic [5:0] OP_BEZ  = 6'd40;
   localparam logic [5:0] OP_BNE  = 6'd41;
   localparam logic [5:0] OP_JMP  = 6'd42;

   typedef struct packed {
      exe_cmd_e exe_cmd;
      logic     wb_en;
      logic     mem_r_en;
      logic     mem_w_en;
      logic     is_imm;
      br_type_e br_type;
      logic     illegal;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE =
      '{EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, 1'b0};

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: control bundle plus a flag saying whether the
// instruction reads its src2 register.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   output ctrl_bundle_t ctrl,
   output logic         src2_used
);

   logic r_type;

   always_comb begin
      ctrl      = CTRL_BUBBLE;
      src2_used = 1'b0;
      r_type    = 1'b0;
      case (opcode)
         OP_NOP:  ;
         OP_ADD:  begin ctrl.exe_cmd = EXE_ADD; r_type = 1'b1; end
         OP_SUB:  begin ctrl.exe_cmd = EXE_SUB; r_type = 1'b1; end
         OP_AND:  begin ctrl.exe_cmd = EXE_AND; r_type = 1'b1; end
         OP_OR:   begin ctrl.exe_cmd = EXE_OR;  r_type = 1'b1; end
         OP_NOR:  begin ctrl.exe_cmd = EXE_NOR; r_type = 1'b1; end
         OP_XOR:  begin ctrl.exe_cmd = EXE_XOR; r_type = 1'b1; end
         OP_SLA:  begin ctrl.exe_cmd = EXE_SHL; r_type = 1'b1; end
         OP_SLL:  begin ctrl.exe_cmd = EXE_SHL; r_type = 1'b1; end
         OP_SRL:  begin ctrl.exe_cmd = EXE_SHR; r_type = 1'b1; end
         OP_SRA:  begin ctrl.exe_cmd = EXE_SRA; r_type = 1'b1; end
         OP_ADDI: begin ctrl.exe_cmd = EXE_ADD; ctrl.wb_en = 1'b1; ctrl.is_imm = 1'b1; end
         OP_SUBI: begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b1; ctrl.is_imm = 1'b1; end
         OP_LD: begin
            ctrl.wb_en    = 1'b1;
            ctrl.mem_r_en = 1'b1;
            ctrl.is_imm   = 1'b1;
         end
         OP_ST: begin
            ctrl.mem_w_en = 1'b1;
            ctrl.is_imm   = 1'b1;
            src2_used     = 1'b1;
         end
         OP_BEZ:  begin ctrl.br_type = BR_BEZ; ctrl.is_imm = 1'b1; end
         OP_BNE:  begin ctrl.br_type = BR_BNE; ctrl.is_imm = 1'b1; src2_used = 1'b1; end
         OP_JMP:  begin ctrl.br_type = BR_JMP; ctrl.is_imm = 1'b1; end
         default: ctrl.illegal = 1'b1;
      endcase
      if (r_type) begin
         ctrl.wb_en = 1'b1;
         src2_used  = 1'b1;
      end
   end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID stage: decodes one instruction per cycle into the registered ID/EXE
// bundle with valid/ready handshake, flush, load-use stall and illegal count.
module id_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      instr,
   output logic             in_ready,
   input  logic             exe_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic [3:0]       exe_cmd,
   output logic             wb_en,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic             is_imm,
   output logic [1:0]       br_type,
   output logic [4:0]       dest,
   output logic [4:0]       src1,
   output logic [4:0]       src2,
   output logic [31:0]      imm,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   ctrl_bundle_t     dec;
   logic             dec_src2_used;
   logic [5:0]       opcode;
   logic [4:0]       in_src2;
   logic             adv, haz, upd, load;

   ctrl_bundle_t     q;
   logic             valid_q;
   logic [4:0]       dest_q, src1_q, src2_q;
   logic [31:0]      imm_q;
   logic [CNT_W-1:0] cnt_q;

   assign opcode = instr[31:26];

   instr_decode u_decode (
      .opcode    (opcode),
      .ctrl      (dec),
      .src2_used (dec_src2_used)
   );

   // Stores read their data register from the dest field.
   assign in_src2 = (opcode == OP_ST) ? instr[25:21] : instr[15:11];

   assign adv = exe_ready | ~valid_q;
   assign haz = valid_q & q.mem_r_en & (dest_q != '0) &
                ((instr[20:16] == dest_q) | (dec_src2_used & (in_src2 == dest_q)));
   assign in_ready = flush | (adv & ~haz);

   // Priority list collapsed: any update either loads the decoded
   // instruction or a bubble; flush forces the bubble.
   assign upd  = flush | adv;
   assign load = ~flush & adv & ~haz & in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         q       <= CTRL_BUBBLE;
         dest_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         imm_q   <= '0;
         cnt_q   <= '0;
      end else if (upd) begin
         valid_q <= load;
         q       <= load ? dec : CTRL_BUBBLE;
         dest_q  <= load ? instr[25:21] : '0;
         src1_q  <= load ? instr[20:16] : '0;
         src2_q  <= load ? in_src2 : '0;
         imm_q   <= load ? sext16(instr[15:0]) : '0;
         if (load && dec.illegal && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid   = valid_q;
   assign exe_cmd     = q.exe_cmd;
   assign wb_en       = q.wb_en;
   assign mem_r_en    = q.mem_r_en;
   assign mem_w_en    = q.mem_w_en;
   assign is_imm      = q.is_imm;
   assign br_type     = q.br_type;
   assign illegal     = q.illegal;
   assign dest        = dest_q;
   assign src1        = src1_q;
   assign src2        = src2_q;
   assign imm         = imm_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus a random stream, all
// checked against a table-driven transaction model of the stage.
module tb_id_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, exe_ready, flush;
   logic [31:0] instr;
   logic        in_ready, out_valid, wb_en, mem_r_en, mem_w_en, is_imm, illegal;
   logic [3:0]  exe_cmd;
   logic [1:0]  br_type;
   logic [4:0]  dest, src1, src2;
   logic [31:0] imm;
   logic [7:0]  illegal_cnt;

   always #5 clk = ~clk;

   id_ctrl_stage #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
      .in_ready(in_ready), .exe_ready(exe_ready), .flush(flush),
      .out_valid(out_valid), .exe_cmd(exe_cmd), .wb_en(wb_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .is_imm(is_imm),
      .br_type(br_type), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
      .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   // Opcode table: expected decode per opcode; untouched entries are illegal.
   int unsigned t_cmd[64], t_br[64];
   bit          t_wb[64], t_mr[64], t_mw[64], t_ii[64], t_s2u[64], t_ill[64];

   // Model of the registered bundle.
   bit          m_valid, m_wb, m_mr, m_mw, m_ii, m_ill;
   int unsigned m_cmd, m_br, m_dest, m_s1, m_s2, m_cnt;
   logic [31:0] m_imm;

   int unsigned n_cmp = 0, n_fail = 0;
   logic        obs_rdy;

   task automatic set_op(input int op, input int unsigned cmd, input bit wb, input bit mr,
                         input bit mw, input bit ii, input int unsigned br, input bit s2u);
      t_cmd[op] = cmd; t_wb[op] = wb; t_mr[op] = mr; t_mw[op] = mw;
      t_ii[op] = ii; t_br[op] = br; t_s2u[op] = s2u; t_ill[op] = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_bubble();
      m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_ii = 0; m_ill = 0;
      m_cmd = 0; m_br = 0; m_dest = 0; m_s1 = 0; m_s2 = 0; m_imm = '0;
   endtask

   task automatic model_load(input logic [31:0] ins);
      int unsigned op;
      op = int'(ins[31:26]);
      m_valid = 1; m_cmd = t_cmd[op]; m_wb = t_wb[op]; m_mr = t_mr[op];
      m_mw = t_mw[op]; m_ii = t_ii[op]; m_br = t_br[op]; m_ill = t_ill[op];
      m_dest = int'(ins[25:21]); m_s1 = int'(ins[20:16]);
      m_s2 = (op == 37) ? int'(ins[25:21]) : int'(ins[15:11]);
      m_imm = {{16{ins[15]}}, ins[15:0]};
      if (t_ill[op] && m_cnt < 255) m_cnt++;
   endtask

   function automatic bit model_haz(input logic [31:0] ins);
      int unsigned op, s1, s2;
      op = int'(ins[31:26]);
      s1 = int'(ins[20:16]);
      s2 = (op == 37) ? int'(ins[25:21]) : int'(ins[15:11]);
      return m_valid && m_mr && m_dest != 0 &&
             (s1 == m_dest || (t_s2u[op] && s2 == m_dest));
   endfunction

   task automatic chk_outputs();
      chk("out_valid",   32'(out_valid),   32'(m_valid));
      chk("exe_cmd",     32'(exe_cmd),     m_cmd);
      chk("wb_en",       32'(wb_en),       32'(m_wb));
      chk("mem_r_en",    32'(mem_r_en),    32'(m_mr));
      chk("mem_w_en",    32'(mem_w_en),    32'(m_mw));
      chk("is_imm",      32'(is_imm),      32'(m_ii));
      chk("br_type",     32'(br_type),     m_br);
      chk("dest",        32'(dest),        m_dest);
      chk("src1",        32'(src1),        m_s1);
      chk("src2",        32'(src2),        m_s2);
      chk("imm",         imm,              m_imm);
      chk("illegal",     32'(illegal),     32'(m_ill));
      chk("illegal_cnt", 32'(illegal_cnt), m_cnt);
   endtask

   // One clock: drive at negedge, check in_ready, update model at posedge,
   // check the bundle at the following negedge.
   task automatic cycle(input bit v, input logic [31:0] ins, input bit er, input bit fl);
      bit adv, hz, rdy;
      in_valid = v; instr = ins; exe_ready = er; flush = fl;
      #1;
      adv = er || !m_valid;
      hz  = model_haz(ins);
      rdy = fl || (adv && !hz);
      obs_rdy = in_ready;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      @(posedge clk);
      if (fl) model_bubble();
      else if (adv) begin
         if (hz || !v) model_bubble();
         else model_load(ins);
      end
      @(negedge clk);
      chk_outputs();
   endtask

   function automatic logic [31:0] mk_r(input int op, input int d, input int s1, input int s2);
      return {6'(op), 5'(d), 5'(s1), 5'(s2), 11'h000};
   endfunction

   function automatic logic [31:0] mk_i(input int op, input int d, input int s1, input logic [15:0] v);
      return {6'(op), 5'(d), 5'(s1), v};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned sc_op[5]  = '{1, 3, 7, 12, 8};
      int unsigned sc_exp[5] = '{0, 2, 6, 10, 7};
      int unsigned pool[18]  = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};
      logic [31:0] add_ins, cur;
      bit          cur_v, er, fl;

      for (int i = 0; i < 64; i++) begin
         t_cmd[i] = 0; t_br[i] = 0; t_wb[i] = 0; t_mr[i] = 0; t_mw[i] = 0;
         t_ii[i] = 0; t_s2u[i] = 0; t_ill[i] = 1;
      end
      set_op(0, 0, 0, 0, 0, 0, 0, 0);
      set_op(1, 0, 1, 0, 0, 0, 0, 1);   set_op(3, 2, 1, 0, 0, 0, 0, 1);
      set_op(5, 4, 1, 0, 0, 0, 0, 1);   set_op(6, 5, 1, 0, 0, 0, 0, 1);
      set_op(7, 6, 1, 0, 0, 0, 0, 1);   set_op(8, 7, 1, 0, 0, 0, 0, 1);
      set_op(9, 8, 1, 0, 0, 0, 0, 1);   set_op(10, 8, 1, 0, 0, 0, 0, 1);
      set_op(11, 9, 1, 0, 0, 0, 0, 1);  set_op(12, 10, 1, 0, 0, 0, 0, 1);
      set_op(32, 0, 1, 0, 0, 1, 0, 0);  set_op(33, 2, 1, 0, 0, 1, 0, 0);
      set_op(36, 0, 1, 1, 0, 1, 0, 0);  set_op(37, 0, 0, 0, 1, 1, 0, 1);
      set_op(40, 0, 0, 0, 0, 1, 1, 0);  set_op(41, 0, 0, 0, 0, 1, 2, 1);
      set_op(42, 0, 0, 0, 0, 1, 3, 0);

      // Reset state
      rst_n = 0; in_valid = 0; instr = '0; exe_ready = 0; flush = 0;
      m_cnt = 0; model_bubble();
      repeat (2) @(negedge clk);
      chk_outputs();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1;

      // Back-to-back ALU stream
      for (int i = 0; i < 5; i++) begin
         cycle(1, mk_r(int'(sc_op[i]), 10 + i, 1, 2), 1, 0);
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_cmd", 32'(exe_cmd), sc_exp[i]);
      end
      cycle(0, '0, 1, 0);

      // Load-use on r3: one bubble, then the ADD
      cycle(1, mk_i(36, 3, 1, 16'h0010), 1, 0);
      add_ins = mk_r(1, 4, 3, 1);
      cycle(1, add_ins, 1, 0);
      chk("ldu_stall_ready", 32'(obs_rdy), 32'd0);
      chk("ldu_bubble", 32'(out_valid), 32'd0);
      cycle(1, add_ins, 1, 0);
      chk("ldu_accept_ready", 32'(obs_rdy), 32'd1);
      chk("ldu_add_dest", 32'(dest), 32'd4);

      // Load to r0 never stalls
      cycle(1, mk_i(36, 0, 1, 16'h0004), 1, 0);
      cycle(1, mk_r(1, 4, 0, 1), 1, 0);
      chk("ld_r0_ready", 32'(obs_rdy), 32'd1);
      chk("ld_r0_valid", 32'(out_valid), 32'd1);

      // Backpressure holds SUBI
      cycle(1, mk_i(33, 5, 2, 16'hFFF0), 1, 0);
      add_ins = mk_r(1, 6, 7, 8);
      for (int i = 0; i < 3; i++) begin
         cycle(1, add_ins, 0, 0);
         chk("hold_ready", 32'(obs_rdy), 32'd0);
         chk("hold_imm", imm, 32'hFFFF_FFF0);
         chk("hold_cmd", 32'(exe_cmd), 32'd2);
      end
      cycle(1, add_ins, 1, 0);

      // Flush under backpressure kills bundle and incoming SUB
      cycle(1, mk_r(3, 9, 1, 2), 0, 1);
      chk("flush_ready", 32'(obs_rdy), 32'd1);
      chk("flush_bubble", 32'(out_valid), 32'd0);
      cycle(0, '0, 1, 0);
      chk("flush_gone", 32'(out_valid), 32'd0);

      // Illegal opcode saturation
      for (int i = 0; i < 300; i++) begin
         cycle(1, mk_r(63, i % 32, (i + 1) % 32, (i + 2) % 32), 1, 0);
         chk("ill_flag", 32'(illegal), 32'd1);
      end
      chk("ill_sat", 32'(illegal_cnt), 32'd255);

      // Random stream obeying the fetch hold rule
      cur_v = 0; cur = '0;
      for (int i = 0; i < 400; i++) begin
         bit hold;
         hold = cur_v && !obs_rdy;
         if (!hold) begin
            int unsigned op;
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                             : pool[$urandom_range(0, 17)];
            cur_v = ($urandom_range(0, 4) != 0);
            cur = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 11'($urandom)};
         end
         er = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 9) == 0);
         cycle(cur_v, cur, er, fl);
         if (fl) obs_rdy = 1'b1;
      end

      // Asynchronous reset between edges
      cycle(0, '0, 1, 0);
      cycle(1, mk_i(32, 7, 1, 16'h8001), 0, 0);
      #2;
      rst_n = 0;
      #1;
      m_cnt = 0; model_bubble();
      chk_outputs();
      chk("areset_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1;
      cycle(1, mk_r(11, 2, 1, 1), 1, 0);
      chk("post_reset_cmd", 32'(exe_cmd), 32'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
